c_drive_sync_rx: RTL

Clocked receiver for the click-style drive/free micropipeline handshake. It takes two-phase tokens (`i_drive` toggles) with bundled data from the asynchronous pipeline's last stage, synchronises them into the `clk` domain, and buffers them in a small FIFO. It presents them as a valid/ready stream and returns `o_free` toggles as credit back to the pipeline. It is the clocked consumer end of a `cArbMerge`/`cFifo` chain.

---
 rtl/c_drive_sync_rx.sv | 114 +++++++++++
 1 files changed

// File: rtl/c_drive_sync_rx.sv
// c_drive_sync_rx: clocked consumer end of a two-phase drive/free micropipeline.
// Synchronises i_drive tokens into clk, buffers the bundled data in a small FIFO,
// presents a valid/ready stream and returns o_free toggles as credit.
//
// Credit bookkeeping: free_pend is set only when a push fills the FIFO, and it is
// cleared only by a pop. Therefore count == DEPTH always implies free_pend == 1.
// A push and a pop at full therefore return exactly one credit (the withheld one)
// and withhold the new one.
module c_drive_sync_rx #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_drive,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_free,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   drv_q, drv_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   free_pend_q, free_pend_d;
    logic                   free_q, free_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic [DATA_W-1:0]      mem_q [DEPTH];

    logic sync_last;
    logic tok;
    logic full;
    logic push;
    logic pop;
    logic ovf_hit;

    // Next-state logic: token detect, push/pop arbitration, occupancy and credit return.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], i_drive};
        sync_last   = sync_q[SYNC_STAGES-1];
        drv_d       = sync_last;
        tok         = sync_last ^ drv_q;
        full        = (count_q == FULL_CNT);
        pop         = valid_q & i_ready;
        // A full FIFO can still accept a token if a pop frees the slot on the same edge.
        push        = tok & (~full | pop);
        ovf_hit     = tok & full & ~pop;

        wptr_d      = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d      = pop  ? rptr_q + PTR_W'(1) : rptr_q;

        count_d     = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        free_d      = free_q ^ ((push & (count_d < FULL_CNT)) | (free_pend_q & pop));
        free_pend_d = (free_pend_q & ~pop) | (push & (count_d == FULL_CNT));
        valid_d     = (count_d != '0);
        ovf_d       = ovf_q | ovf_hit;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q      <= '0;
            drv_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            free_pend_q <= 1'b0;
            free_q      <= 1'b0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            drv_q       <= drv_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            free_pend_q <= free_pend_d;
            free_q      <= free_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because valid/count gate their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= i_data;
        end
    end

    assign o_free     = free_q;
    assign o_valid    = valid_q;
    assign o_data     = mem_q[rptr_q];
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule
